// File: rtl/zuofu_pkg.sv
// Shared key definitions for the keyboard front end, state machine and color mapper.
// Key codes double as bit positions in the held/pending masks.
package zuofu_pkg;

   typedef enum logic [2:0] {
      KEY_UP     = 3'd0,
      KEY_DOWN   = 3'd1,
      KEY_LEFT   = 3'd2,
      KEY_RIGHT  = 3'd3,
      KEY_SELECT = 3'd4,
      KEY_ACTION = 3'd5
   } key_e;

   localparam int NUM_KEYS = int'(KEY_ACTION) + 1;
   localparam int EVT_W    = 4;

   localparam logic [7:0] HID_UP     = 8'h1A;
   localparam logic [7:0] HID_DOWN   = 8'h16;
   localparam logic [7:0] HID_LEFT   = 8'h04;
   localparam logic [7:0] HID_RIGHT  = 8'h07;
   localparam logic [7:0] HID_SELECT = 8'h28;
   localparam logic [7:0] HID_ACTION = 8'h2C;

   localparam logic [7:0] KEY_SCANCODE [NUM_KEYS] =
      '{HID_UP, HID_DOWN, HID_LEFT, HID_RIGHT, HID_SELECT, HID_ACTION};

   // Scancode 0x00 matches no entry, so an empty slot contributes nothing.
   function automatic logic [NUM_KEYS-1:0] keyMask(input logic [7:0] scan);
      logic [NUM_KEYS-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (scan == KEY_SCANCODE[i]) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through event queue; a push into a full queue is dropped
// unless a pop frees a slot in the same cycle.
module event_fifo
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
)
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             drop_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wrPtr_q, rdPtr_q;
   logic [CW-1:0]    count_q;
   logic             full, doPop, doPush;

   assign full    = (count_q == CW'(DEPTH));
   assign valid_o = (count_q != '0);
   assign doPop   = pop_i && valid_o;
   assign doPush  = push_i && (!full || doPop);
   assign drop_o  = push_i && !doPush;
   assign data_o  = valid_o ? mem_q[rdPtr_q] : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
            wrPtr_q        <= wrPtr_q + PW'(1);
         end
         if (doPop) rdPtr_q <= rdPtr_q + PW'(1);
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/keycode_events.sv
// Turns the two-slot HID keycode into a queue of press and auto-repeat events,
// with frame-paced repeats for the most recently pressed direction key.
module keycode_events
   import zuofu_pkg::*;
#(
   parameter int REPEAT_DELAY = 20,
   parameter int REPEAT_RATE  = 6,
   parameter int FIFO_DEPTH   = 4
)
(
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic [15:0]         keycode,
   input  logic                frame_clk,
   output logic                evt_valid,
   output logic [2:0]          evt_code,
   output logic                evt_repeat,
   input  logic                evt_ready,
   output logic [NUM_KEYS-1:0] held,
   output logic                overflow
);

   localparam int CNT_W = $clog2(REPEAT_DELAY + 1);

   logic [NUM_KEYS-1:0] held_q, heldPrev_q, pending_q, pending_d, rise, grantMask;
   logic                syncA_q, syncB_q, syncC_q, tick;
   logic                trkActive_q, trkActive_d, repReq_q, repReq_d, overflow_q;
   logic [1:0]          trkKey_q, trkKey_d, newestDir;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          lowIdx;
   logic                hasPending, push, drop;
   logic [EVT_W-1:0]    pushData, headData;

   assign rise       = held_q & ~heldPrev_q;
   assign tick       = syncB_q & ~syncC_q;
   assign hasPending = |pending_q;

   always_comb begin
      lowIdx    = '0;
      newestDir = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (pending_q[i]) lowIdx = 3'(i);
      end
      for (int i = 0; i < 4; i++) begin
         if (rise[i]) newestDir = 2'(i);
      end
      grantMask = hasPending ? (NUM_KEYS'(1) << lowIdx) : '0;
      pending_d = (pending_q & ~grantMask) | rise;
   end

   // A pending press owns the push slot; a waiting repeat simply holds over a cycle.
   assign push     = hasPending || repReq_q;
   assign pushData = hasPending ? {lowIdx, 1'b0} : {1'b0, trkKey_q, 1'b1};

   always_comb begin
      trkActive_d = trkActive_q;
      trkKey_d    = trkKey_q;
      cnt_d       = cnt_q;
      repReq_d    = repReq_q && hasPending;
      if (|rise[3:0]) begin
         trkActive_d = 1'b1;
         trkKey_d    = newestDir;
         cnt_d       = '0;
         repReq_d    = 1'b0;
      end else if (trkActive_q) begin
         if (!held_q[trkKey_q]) begin
            trkActive_d = 1'b0;
            repReq_d    = 1'b0;
         end else if (tick) begin
            if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
               repReq_d = 1'b1;
               cnt_d    = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         held_q      <= '0;
         heldPrev_q  <= '0;
         pending_q   <= '0;
         syncA_q     <= 1'b0;
         syncB_q     <= 1'b0;
         syncC_q     <= 1'b0;
         trkActive_q <= 1'b0;
         trkKey_q    <= '0;
         cnt_q       <= '0;
         repReq_q    <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         held_q      <= keyMask(keycode[7:0]) | keyMask(keycode[15:8]);
         heldPrev_q  <= held_q;
         pending_q   <= pending_d;
         syncA_q     <= frame_clk;
         syncB_q     <= syncA_q;
         syncC_q     <= syncB_q;
         trkActive_q <= trkActive_d;
         trkKey_q    <= trkKey_d;
         cnt_q       <= cnt_d;
         repReq_q    <= repReq_d;
         overflow_q  <= overflow_q | drop;
      end
   end

   event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVT_W)
   ) u_fifo (
      .clk_i   (Clk),
      .rst_ni  (Reset_n),
      .push_i  (push),
      .data_i  (pushData),
      .pop_i   (evt_ready),
      .valid_o (evt_valid),
      .data_o  (headData),
      .drop_o  (drop)
   );

   assign evt_code   = headData[3:1];
   assign evt_repeat = headData[0];
   assign held       = held_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_keycode_events.sv
// Directed self-checking bench for keycode_events: presses, serialization,
// frame-paced repeats, queue overflow and reset behaviour.
module tb_keycode_events;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic [15:0] keycode;
   logic        frame_clk;
   logic        evt_valid, evt_repeat, evt_ready, overflow;
   logic [2:0]  evt_code;
   logic [5:0]  held;

   int compareCnt = 0;
   int failCnt    = 0;
   int repCount   = 0;
   int pressSeen  = 0;
   int badRepCode = 0;
   int repTicks [8];

   keycode_events #(
      .REPEAT_DELAY (20),
      .REPEAT_RATE  (6),
      .FIFO_DEPTH   (4)
   ) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .keycode    (keycode),
      .frame_clk  (frame_clk),
      .evt_valid  (evt_valid),
      .evt_code   (evt_code),
      .evt_repeat (evt_repeat),
      .evt_ready  (evt_ready),
      .held       (held),
      .overflow   (overflow)
   );

   always #10 Clk = ~Clk;

   // Drive inputs at a falling edge, then advance to the next falling edge.
   task automatic applyStimulus(input logic [15:0] kc, input logic rdy);
      keycode   = kc;
      evt_ready = rdy;
      @(negedge Clk);
   endtask

   task automatic stepCycles(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      compareCnt++;
      assert (observed === expected) else begin
         failCnt++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic sampleRepeat(input int idx);
      if (evt_valid === 1'b1) begin
         if (evt_repeat === 1'b1) begin
            if (repCount < 8) repTicks[repCount] = idx;
            repCount++;
            if (evt_code !== 3'd3) badRepCode++;
         end else begin
            pressSeen++;
         end
      end
   endtask

   task automatic frameTick(input int idx);
      frame_clk = 1'b1;
      repeat (3) begin
         @(negedge Clk);
         sampleRepeat(idx);
      end
      frame_clk = 1'b0;
      repeat (3) begin
         @(negedge Clk);
         sampleRepeat(idx);
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      Reset_n   = 1'b0;
      keycode   = 16'h0000;
      frame_clk = 1'b0;
      evt_ready = 1'b0;
      stepCycles(3);
      checkOutput("rst_valid", 16'(evt_valid), 16'h0);
      checkOutput("rst_code", 16'(evt_code), 16'h0);
      checkOutput("rst_repeat", 16'(evt_repeat), 16'h0);
      checkOutput("rst_held", 16'(held), 16'h0);
      checkOutput("rst_overflow", 16'(overflow), 16'h0);
      Reset_n = 1'b1;
      stepCycles(2);

      $display("[TB] single UP press");
      applyStimulus(16'h001A, 1'b0);
      checkOutput("up_held", 16'(held), 16'h01);
      stepCycles(1);
      checkOutput("up_not_yet", 16'(evt_valid), 16'h0);
      applyStimulus(16'h0000, 1'b0);
      checkOutput("up_valid", 16'(evt_valid), 16'h1);
      checkOutput("up_code", 16'(evt_code), 16'h0);
      checkOutput("up_repeat", 16'(evt_repeat), 16'h0);
      checkOutput("up_released", 16'(held), 16'h0);
      applyStimulus(16'h0000, 1'b1);
      checkOutput("up_popped", 16'(evt_valid), 16'h0);
      stepCycles(4);
      checkOutput("up_single", 16'(evt_valid), 16'h0);

      $display("[TB] simultaneous SELECT+ACTION");
      applyStimulus(16'h2C28, 1'b1);
      checkOutput("sa_held", 16'(held), 16'h30);
      applyStimulus(16'h0000, 1'b1);
      checkOutput("sa_not_yet", 16'(evt_valid), 16'h0);
      stepCycles(1);
      checkOutput("sa_first_valid", 16'(evt_valid), 16'h1);
      checkOutput("sa_first_code", 16'(evt_code), 16'h4);
      stepCycles(1);
      checkOutput("sa_second_valid", 16'(evt_valid), 16'h1);
      checkOutput("sa_second_code", 16'(evt_code), 16'h5);
      stepCycles(1);
      checkOutput("sa_empty", 16'(evt_valid), 16'h0);

      $display("[TB] RIGHT held for 40 frames");
      applyStimulus(16'h0007, 1'b1);
      checkOutput("rt_held", 16'(held), 16'h08);
      stepCycles(2);
      checkOutput("rt_press_valid", 16'(evt_valid), 16'h1);
      checkOutput("rt_press_code", 16'(evt_code), 16'h3);
      checkOutput("rt_press_repeat", 16'(evt_repeat), 16'h0);
      stepCycles(1);
      checkOutput("rt_press_popped", 16'(evt_valid), 16'h0);
      for (int t = 1; t <= 40; t++) frameTick(t);
      checkOutput("rt_repeat_count", 16'(repCount), 16'd4);
      checkOutput("rt_no_press", 16'(pressSeen), 16'd0);
      checkOutput("rt_repeat_code", 16'(badRepCode), 16'd0);
      checkOutput("rt_tick0", 16'(repTicks[0]), 16'd20);
      checkOutput("rt_tick1", 16'(repTicks[1]), 16'd26);
      checkOutput("rt_tick2", 16'(repTicks[2]), 16'd32);
      checkOutput("rt_tick3", 16'(repTicks[3]), 16'd38);
      applyStimulus(16'h0000, 1'b1);
      stepCycles(3);

      $display("[TB] six presses into a stalled queue");
      applyStimulus(16'h161A, 1'b0);
      applyStimulus(16'h0704, 1'b0);
      applyStimulus(16'h282C, 1'b0);
      applyStimulus(16'h0000, 1'b0);
      stepCycles(6);
      checkOutput("ovf_flag", 16'(overflow), 16'h1);
      checkOutput("ovf_valid", 16'(evt_valid), 16'h1);
      checkOutput("ovf_pop0", 16'(evt_code), 16'h0);
      applyStimulus(16'h0000, 1'b1);
      checkOutput("ovf_pop1", 16'(evt_code), 16'h1);
      applyStimulus(16'h0000, 1'b1);
      checkOutput("ovf_pop2", 16'(evt_code), 16'h2);
      applyStimulus(16'h0000, 1'b1);
      checkOutput("ovf_pop3", 16'(evt_code), 16'h3);
      applyStimulus(16'h0000, 1'b1);
      checkOutput("ovf_drained", 16'(evt_valid), 16'h0);
      checkOutput("ovf_sticky", 16'(overflow), 16'h1);

      Reset_n = 1'b0;
      #1;
      checkOutput("rst2_overflow", 16'(overflow), 16'h0);
      @(negedge Clk);
      Reset_n   = 1'b1;
      evt_ready = 1'b0;
      stepCycles(2);

      $display("[TB] push and pop together on a full queue");
      applyStimulus(16'h161A, 1'b0);
      applyStimulus(16'h0704, 1'b0);
      applyStimulus(16'h0000, 1'b0);
      applyStimulus(16'h0000, 1'b0);
      applyStimulus(16'h0028, 1'b0);
      applyStimulus(16'h0000, 1'b0);
      checkOutput("full_head", 16'(evt_code), 16'h0);
      applyStimulus(16'h0000, 1'b1);
      checkOutput("full_no_drop", 16'(overflow), 16'h0);
      checkOutput("full_pop1", 16'(evt_code), 16'h1);
      applyStimulus(16'h0000, 1'b1);
      checkOutput("full_pop2", 16'(evt_code), 16'h2);
      applyStimulus(16'h0000, 1'b1);
      checkOutput("full_pop3", 16'(evt_code), 16'h3);
      applyStimulus(16'h0000, 1'b1);
      checkOutput("full_pop4", 16'(evt_code), 16'h4);
      applyStimulus(16'h0000, 1'b1);
      checkOutput("full_empty", 16'(evt_valid), 16'h0);
      checkOutput("full_ovf_clear", 16'(overflow), 16'h0);

      $display("[TB] reset with queued events");
      applyStimulus(16'h161A, 1'b0);
      applyStimulus(16'h0004, 1'b0);
      applyStimulus(16'h0000, 1'b0);
      stepCycles(3);
      checkOutput("q3_valid", 16'(evt_valid), 16'h1);
      checkOutput("q3_head", 16'(evt_code), 16'h0);
      Reset_n = 1'b0;
      keycode = 16'h0016;
      #1;
      checkOutput("q3_rst_valid", 16'(evt_valid), 16'h0);
      checkOutput("q3_rst_held", 16'(held), 16'h0);
      @(negedge Clk);
      Reset_n = 1'b1;
      stepCycles(1);
      checkOutput("post_held", 16'(held), 16'h02);
      checkOutput("post_not_yet", 16'(evt_valid), 16'h0);
      stepCycles(2);
      checkOutput("post_valid", 16'(evt_valid), 16'h1);
      checkOutput("post_code", 16'(evt_code), 16'h1);
      checkOutput("post_repeat", 16'(evt_repeat), 16'h0);
      applyStimulus(16'h0016, 1'b1);
      checkOutput("post_popped", 16'(evt_valid), 16'h0);
      stepCycles(5);
      checkOutput("post_single", 16'(evt_valid), 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, failCnt);
      $finish;
   end

endmodule

// File: doc/keycode_events.md
KEYCODE_EVENTS -- requirements
Module: keycode_events

Interface
REQ-001 Parameter REPEAT_DELAY, default 20, frames a direction key is held before the first repeat event.
REQ-002 Parameter REPEAT_RATE, default 6, frames between subsequent repeat events.
REQ-003 Parameter FIFO_DEPTH, default 4, event queue entries; power of two, at least 2.
REQ-004 Clk  input  1  system clock, 50 MHz; one clock, all logic on its rising edge.
REQ-005 Reset_n  input  1  reset; asynchronous, active-low.
REQ-006 keycode  input  16  two USB HID key slots from the SoC keycode PIO ([7:0] slot 0, [15:8] slot 1); Clk domain.
REQ-007 frame_clk  input  1  raw VGA vertical sync; asynchronous to Clk.
REQ-008 evt_valid  output  1  head of the event queue is valid.
REQ-009 evt_code  output  3  key of head event: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 SELECT, 5 ACTION.
REQ-010 evt_repeat  output  1  head event is an auto-repeat (1) or a fresh press (0).
REQ-011 evt_ready  input  1  consumer accepts the head event.
REQ-012 held  output  6  level flag per key, bit index = key code.
REQ-013 overflow  output  1  sticky flag: an event was dropped.

Function
REQ-014 The key map SHALL be 0x1A UP, 0x16 DOWN, 0x04 LEFT, 0x07 RIGHT, 0x28 SELECT, 0x2C ACTION; held[i] SHALL be 1 when either slot equals key i, registered, so it lags keycode by 1 cycle.
REQ-015 A press SHALL be detected when held[i] goes from 0 to 1; it sets bit i of a pending-press mask.
REQ-016 Each cycle, the lowest set pending bit SHALL be moved into the FIFO with evt_repeat=0. This serializes simultaneous presses in ascending code order, one per cycle.
REQ-017 frame_clk SHALL pass through a 2-flop synchronizer; its synchronized rising edge forms a 1-cycle frame tick.
REQ-018 A repeat tracker SHALL follow the most recently pressed direction key (codes 0-3) and reset a frame counter on that press.
REQ-019 While the tracked key stays held, the tracker SHALL request a repeat event (evt_repeat=1) on the frame tick where the counter reaches REPEAT_DELAY, and then every REPEAT_RATE ticks.
REQ-020 When the tracked key is released, the tracker SHALL idle with no further repeats, even if other directions are still held.
REQ-021 A repeat request SHALL yield to a pending press in the same cycle and be retried the next cycle; it is never lost unless the FIFO is full.
REQ-022 The FIFO SHALL be first-word-fall-through: evt_valid=1 when non-empty; pop on evt_valid&&evt_ready.
REQ-023 A push to a full FIFO SHALL be dropped and set overflow; a simultaneous pop and push when full SHALL succeed with no drop.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH with a count of log2(FIFO_DEPTH)+1 bits; there is no read on empty.
REQ-025 A key released and re-pressed while its pending bit is still set SHALL produce one event only.
REQ-026 keycode 0x00 in both slots SHALL clear all held bits; it generates no events.

Reset
REQ-027 Asserting Reset_n low SHALL immediately set to 0: evt_valid, evt_code, evt_repeat, held, overflow, the pending mask, FIFO pointers and count, the repeat tracker, the frame counter and the synchronizer flops.
REQ-028 Reset asserted mid-operation SHALL discard all queued events; the first cycle after release treats currently pressed keys as new presses.

Structure
REQ-029 Key codes, the HID scancode constants and the key_e enum SHALL live in the shared package zuofu_pkg so that state_machine and color_mapper can reuse them.
REQ-030 The FIFO SHALL be a separate sub-module, event_fifo, parameterized on depth and width (4 bits: code plus repeat).

Verification
REQ-031 keycode 0x0000 -> 0x001A held 2 cycles -> one event {code 0, repeat 0}; held=6'b000001.
REQ-032 keycode 0x2C28 in one cycle -> events SELECT then ACTION on consecutive cycles, evt_ready=1.
REQ-033 Hold 0x0007 for 40 frame ticks -> 1 press, then repeats at ticks 20, 26, 32, 38 (4 repeats, code 3).
REQ-034 evt_ready=0, press 6 distinct keys -> 4 queued, overflow=1, then pops in order 0, 1, 2, 3.
REQ-035 FIFO full with evt_ready=1 and a new press in the same cycle -> no drop, overflow stays 0.
REQ-036 Reset_n low while 3 events are queued -> evt_valid=0 immediately; after release with 0x0016 held -> one DOWN press event.
